cim_neuron_mac: RTL and testbench

CIM_NEURON_MAC -- requirements
Module: cim_neuron_mac

---
 rtl/cim_pkg.sv | 50 +++++
 rtl/cim_mac_lane.sv | 39 +++
 rtl/cim_neuron_mac.sv | 135 +++++++++++++
 tb/tb_cim_neuron_mac.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cim_pkg.sv
// Shared types and elaboration helpers for the compute-in-memory neuron MAC.
// Holds the FSM state enum, the ceil-div/clog2 helpers and the output saturation function.
package cim_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int SAT_W = 64;

    typedef struct packed {
        logic                    clip;
        logic signed [SAT_W-1:0] val;
    } sat_t;

    function automatic int ceil_div(input int a, input int b);
        return (a + b - 1) / b;
    endfunction

    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) r = i + 1;
        end
        return r;
    endfunction

    // Clamp a wide signed value into the signed range of an out_w-bit result.
    function automatic sat_t saturate(input logic signed [SAT_W-1:0] v, input int out_w);
        sat_t                    res;
        logic signed [SAT_W-1:0] maxv;
        logic signed [SAT_W-1:0] minv;
        maxv     = (64'sd1 <<< (out_w - 1)) - 64'sd1;
        minv     = -(64'sd1 <<< (out_w - 1));
        res.clip = 1'b0;
        res.val  = v;
        if (v > maxv) begin
            res.clip = 1'b1;
            res.val  = maxv;
        end else if (v < minv) begin
            res.clip = 1'b1;
            res.val  = minv;
        end
        return res;
    endfunction

endpackage

// File: rtl/cim_mac_lane.sv
// Combinational group multiplier: LANES signed activation*weight products
// reduced by a pairwise adder tree into one signed group sum.
module cim_mac_lane #(
    parameter int LANES = 2,
    parameter int A_W   = 9,
    parameter int W_W   = 2,
    parameter int SUM_W = 14
) (
    input  logic [LANES*A_W-1:0]    i_act,
    input  logic [LANES*W_W-1:0]    i_wgt,
    output logic signed [SUM_W-1:0] o_sum
);

    logic signed [A_W-1:0]     w_a;
    logic signed [W_W-1:0]     w_b;
    logic signed [A_W+W_W-1:0] w_prod;
    logic signed [SUM_W-1:0]   w_node [LANES];

    // Products land in w_node, then each tree level folds node i+s into node i.
    always_comb begin
        w_a    = '0;
        w_b    = '0;
        w_prod = '0;
        w_node = '{default: '0};
        for (int l = 0; l < LANES; l++) begin
            w_a       = i_act[l*A_W +: A_W];
            w_b       = i_wgt[l*W_W +: W_W];
            w_prod    = w_a * w_b;
            w_node[l] = SUM_W'(w_prod);
        end
        for (int s = 1; s < LANES; s = s * 2) begin
            for (int i = 0; i + s < LANES; i = i + 2 * s) begin
                w_node[i] = w_node[i] + w_node[i+s];
            end
        end
        o_sum = w_node[0];
    end

endmodule

// File: rtl/cim_neuron_mac.sv
// Single neuron dot product, LANES products per cycle, saturated to OUT_W bits.
// Optional macro CIM_RELU_EN clamps negative saturated results to zero.
module cim_neuron_mac
    import cim_pkg::*;
#(
    parameter int N_IN  = 8,
    parameter int A_W   = 9,
    parameter int W_W   = 2,
    parameter int LANES = 2,
    parameter int OUT_W = 12
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [N_IN*A_W-1:0]     act_vec,
    input  logic [N_IN*W_W-1:0]     wgt_vec,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [OUT_W-1:0] out_neuron,
    output logic                    out_sat
);

    localparam int NG    = ceil_div(N_IN, LANES);
    localparam int ACC_W = A_W + W_W + clog2(N_IN);
    localparam int G_W   = (clog2(NG + 1) < 1) ? 1 : clog2(NG + 1);

    state_t                  r_state;
    logic [N_IN*A_W-1:0]     r_act;
    logic [N_IN*W_W-1:0]     r_wgt;
    logic signed [ACC_W-1:0] r_acc;
    logic [G_W-1:0]          r_g;
    logic                    r_in_ready;
    logic                    r_out_valid;
    logic signed [OUT_W-1:0] r_out_neuron;
    logic                    r_out_sat;

    logic [LANES*A_W-1:0]    w_act_grp;
    logic [LANES*W_W-1:0]    w_wgt_grp;
    logic signed [ACC_W-1:0] w_grp_sum;
    int                      w_idx;
    sat_t                    w_sat;
    logic signed [OUT_W-1:0] w_sat_val;
    logic signed [OUT_W-1:0] w_result;

    // Route the pairs of group r_g to the lanes; lanes past N_IN stay zero.
    always_comb begin
        w_act_grp = '0;
        w_wgt_grp = '0;
        w_idx     = 0;
        for (int l = 0; l < LANES; l++) begin
            w_idx = int'(r_g) * LANES + l;
            if (w_idx < N_IN) begin
                w_act_grp[l*A_W +: A_W] = r_act[w_idx*A_W +: A_W];
                w_wgt_grp[l*W_W +: W_W] = r_wgt[w_idx*W_W +: W_W];
            end
        end
    end

    cim_mac_lane #(
        .LANES (LANES),
        .A_W   (A_W),
        .W_W   (W_W),
        .SUM_W (ACC_W)
    ) u_lane (
        .i_act (w_act_grp),
        .i_wgt (w_wgt_grp),
        .o_sum (w_grp_sum)
    );

    always_comb begin
        w_sat     = saturate(SAT_W'(r_acc), OUT_W);
        w_sat_val = OUT_W'(w_sat.val);
`ifdef CIM_RELU_EN
        w_result  = w_sat_val[OUT_W-1] ? '0 : w_sat_val;
`else
        w_result  = w_sat_val;
`endif
    end

    // r_g walks 0..NG-1 accumulating one group per cycle; the cycle with
    // r_g == NG saturates the finished sum and publishes it on entry to DONE.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= IDLE;
            r_in_ready   <= 1'b1;
            r_out_valid  <= 1'b0;
            r_out_neuron <= '0;
            r_out_sat    <= 1'b0;
            r_acc        <= '0;
            r_g          <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid && r_in_ready) begin
                        r_act      <= act_vec;
                        r_wgt      <= wgt_vec;
                        r_acc      <= '0;
                        r_g        <= '0;
                        r_in_ready <= 1'b0;
                        r_state    <= ACC;
                    end
                end
                ACC: begin
                    if (r_g != G_W'(NG)) begin
                        r_acc <= r_acc + w_grp_sum;
                        r_g   <= r_g + G_W'(1);
                    end else begin
                        r_out_neuron <= w_result;
                        r_out_sat    <= w_sat.clip;
                        r_out_valid  <= 1'b1;
                        r_state      <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= IDLE;
                    end
                end
                default: begin
                    r_state    <= IDLE;
                    r_in_ready <= 1'b1;
                end
            endcase
        end
    end

    assign in_ready   = r_in_ready;
    assign out_valid  = r_out_valid;
    assign out_neuron = r_out_neuron;
    assign out_sat    = r_out_sat;

endmodule

// File: tb/tb_cim_neuron_mac.sv
// Self-checking bench for cim_neuron_mac: four instances (LANES 2,1,3,8) driven by
// directed vectors, stall/reset sequences and randomized vectors against a dot-product model.
module tb_cim_neuron_mac;

    localparam int N_IN  = 8;
    localparam int A_W   = 9;
    localparam int W_W   = 2;
    localparam int OUT_W = 12;
    localparam int NDUT  = 4;

    logic                    clk = 1'b0;
    logic                    reset;
    logic [N_IN*A_W-1:0]     actVec;
    logic [N_IN*W_W-1:0]     wgtVec;
    logic [NDUT-1:0]         inValid;
    logic [NDUT-1:0]         inReady;
    logic [NDUT-1:0]         outValid;
    logic [NDUT-1:0]         outReady;
    logic [NDUT-1:0]         outSat;
    logic signed [OUT_W-1:0] outNeuron [NDUT];

    int nChecks = 0;
    int nPassed = 0;

    typedef struct {
        string               name;
        logic [N_IN*A_W-1:0] act;
        logic [N_IN*W_W-1:0] wgt;
        int                  expNeuron;
        bit                  expSat;
    } vec_t;

    vec_t vecs [4];
    int   expLat [NDUT] = '{5, 9, 4, 2};

    always #5 clk = ~clk;

    generate
        for (genvar g = 0; g < NDUT; g++) begin : gDut
            localparam int LN = (g == 0) ? 2 : (g == 1) ? 1 : (g == 2) ? 3 : 8;
            cim_neuron_mac #(
                .N_IN  (N_IN),
                .A_W   (A_W),
                .W_W   (W_W),
                .LANES (LN),
                .OUT_W (OUT_W)
            ) uDut (
                .clk        (clk),
                .reset      (reset),
                .in_valid   (inValid[g]),
                .in_ready   (inReady[g]),
                .act_vec    (actVec),
                .wgt_vec    (wgtVec),
                .out_valid  (outValid[g]),
                .out_ready  (outReady[g]),
                .out_neuron (outNeuron[g]),
                .out_sat    (outSat[g])
            );
        end
    endgenerate

    function automatic int lanesOf(input int d);
        case (d)
            0:       return 2;
            1:       return 1;
            2:       return 3;
            default: return 8;
        endcase
    endfunction

    // Plain dot product, then clip to the signed OUT_W range.
    function automatic void refModel(input logic [N_IN*A_W-1:0] a, input logic [N_IN*W_W-1:0] w,
                                     output int val, output bit sat);
        int                    sum;
        logic signed [A_W-1:0] ai;
        logic signed [W_W-1:0] wi;
        sum = 0;
        for (int i = 0; i < N_IN; i++) begin
            ai  = a[i*A_W +: A_W];
            wi  = w[i*W_W +: W_W];
            sum = sum + int'(ai) * int'(wi);
        end
        sat = 1'b0;
        val = sum;
        if (sum > (1 << (OUT_W - 1)) - 1) begin
            val = (1 << (OUT_W - 1)) - 1;
            sat = 1'b1;
        end else if (sum < -(1 << (OUT_W - 1))) begin
            val = -(1 << (OUT_W - 1));
            sat = 1'b1;
        end
`ifdef CIM_RELU_EN
        if (val < 0) val = 0;
`endif
    endfunction

    function automatic logic [N_IN*A_W-1:0] randAct();
        logic [N_IN*A_W-1:0] a;
        for (int i = 0; i < N_IN; i++) a[i*A_W +: A_W] = A_W'($urandom_range(0, 511));
        return a;
    endfunction

    function automatic logic [N_IN*W_W-1:0] randWgt();
        logic [N_IN*W_W-1:0] w;
        for (int i = 0; i < N_IN; i++) w[i*W_W +: W_W] = W_W'($urandom_range(0, 3));
        return w;
    endfunction

    task automatic checkOutput(input string name, input int actual, input int expected);
        nChecks++;
        if (actual == expected) nPassed++;
        else $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    endtask

    // Present one vector to DUT d, scramble the inputs after the accepting edge,
    // and count edges until out_valid rises (bounded).
    task automatic applyStimulus(input int d, input logic [N_IN*A_W-1:0] act,
                                 input logic [N_IN*W_W-1:0] wgt, input bit holdReady,
                                 output int lat);
        checkOutput($sformatf("in_ready before accept L%0d", lanesOf(d)), int'(inReady[d]), 1);
        actVec      = act;
        wgtVec      = wgt;
        outReady[d] = holdReady;
        inValid[d]  = 1'b1;
        @(posedge clk);
        #1;
        inValid[d] = 1'b0;
        actVec     = randAct();
        wgtVec     = randWgt();
        lat        = 0;
        do begin
            @(posedge clk);
            #1;
            lat++;
        end while (!outValid[d] && lat < 40);
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int  lat;
        int  val;
        bit  sat;
        bit  seen;
        logic [N_IN*A_W-1:0] a;
        logic [N_IN*W_W-1:0] w;

        vecs[0].name = "ones";
        vecs[1].name = "posclip";
        vecs[2].name = "negclip";
        vecs[3].name = "ramp";
        for (int i = 0; i < N_IN; i++) begin
            vecs[0].act[i*A_W +: A_W] = A_W'(1);
            vecs[0].wgt[i*W_W +: W_W] = W_W'(1);
            vecs[1].act[i*A_W +: A_W] = A_W'(-256);
            vecs[1].wgt[i*W_W +: W_W] = W_W'(-2);
            vecs[2].act[i*A_W +: A_W] = A_W'(255);
            vecs[2].wgt[i*W_W +: W_W] = W_W'(-2);
            vecs[3].act[i*A_W +: A_W] = A_W'(i + 1);
            vecs[3].wgt[i*W_W +: W_W] = (i % 2 == 0) ? W_W'(1) : W_W'(-1);
        end
        vecs[0].expNeuron = 8;    vecs[0].expSat = 1'b0;
        vecs[1].expNeuron = 2047; vecs[1].expSat = 1'b1;
`ifdef CIM_RELU_EN
        vecs[2].expNeuron = 0;    vecs[2].expSat = 1'b1;
        vecs[3].expNeuron = 0;    vecs[3].expSat = 1'b0;
`else
        vecs[2].expNeuron = -2048; vecs[2].expSat = 1'b1;
        vecs[3].expNeuron = -4;    vecs[3].expSat = 1'b0;
`endif

        reset    = 1'b1;
        inValid  = '0;
        outReady = '0;
        actVec   = '0;
        wgtVec   = '0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset out_valid", int'(outValid[0]), 0);
        checkOutput("reset out_neuron", int'(outNeuron[0]), 0);
        checkOutput("reset out_sat", int'(outSat[0]), 0);
        checkOutput("reset in_ready", int'(inReady[0]), 1);
        reset = 1'b0;

        for (int v = 0; v < 4; v++) begin
            for (int d = 0; d < NDUT; d++) begin
                applyStimulus(d, vecs[v].act, vecs[v].wgt, 1'b1, lat);
                checkOutput($sformatf("%s/L%0d neuron", vecs[v].name, lanesOf(d)),
                            int'(outNeuron[d]), vecs[v].expNeuron);
                checkOutput($sformatf("%s/L%0d sat", vecs[v].name, lanesOf(d)),
                            int'(outSat[d]), int'(vecs[v].expSat));
                checkOutput($sformatf("%s/L%0d latency", vecs[v].name, lanesOf(d)), lat, expLat[d]);
                @(posedge clk);
                #1;
                checkOutput($sformatf("%s/L%0d xfer", vecs[v].name, lanesOf(d)), int'(outValid[d]), 0);
                outReady[d] = 1'b0;
            end
        end

        $display("[TB] stall sequence");
        refModel(vecs[3].act, vecs[3].wgt, val, sat);
        applyStimulus(0, vecs[3].act, vecs[3].wgt, 1'b0, lat);
        checkOutput("stall latency", lat, expLat[0]);
        for (int k = 0; k < 3; k++) begin
            actVec     = randAct();
            wgtVec     = randWgt();
            inValid[0] = 1'b1;
            @(posedge clk);
            #1;
            inValid[0] = 1'b0;
            checkOutput($sformatf("stall%0d out_valid", k), int'(outValid[0]), 1);
            checkOutput($sformatf("stall%0d neuron", k), int'(outNeuron[0]), val);
            checkOutput($sformatf("stall%0d in_ready", k), int'(inReady[0]), 0);
        end
        outReady[0] = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("stall xfer out_valid", int'(outValid[0]), 0);
        checkOutput("stall xfer in_ready", int'(inReady[0]), 1);
        outReady[0] = 1'b0;
        seen = 1'b0;
        repeat (12) begin
            @(posedge clk);
            #1;
            seen |= outValid[0];
        end
        checkOutput("stall no ghost txn", int'(seen), 0);

        $display("[TB] reset abort sequence");
        actVec     = randAct();
        wgtVec     = randWgt();
        inValid[0] = 1'b1;
        @(posedge clk);
        #1;
        inValid[0] = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        checkOutput("abort out_valid", int'(outValid[0]), 0);
        checkOutput("abort in_ready", int'(inReady[0]), 1);
        checkOutput("abort out_neuron", int'(outNeuron[0]), 0);
        seen = 1'b0;
        repeat (10) begin
            @(posedge clk);
            #1;
            seen |= outValid[0];
        end
        checkOutput("abort no pulse", int'(seen), 0);
        a = randAct();
        w = randWgt();
        refModel(a, w, val, sat);
        applyStimulus(0, a, w, 1'b1, lat);
        checkOutput("post-abort neuron", int'(outNeuron[0]), val);
        checkOutput("post-abort sat", int'(outSat[0]), int'(sat));
        checkOutput("post-abort latency", lat, expLat[0]);
        @(posedge clk);
        #1;
        outReady[0] = 1'b0;

        $display("[TB] random vectors");
        for (int k = 0; k < 24; k++) begin
            int d;
            d = k % NDUT;
            a = randAct();
            w = randWgt();
            refModel(a, w, val, sat);
            applyStimulus(d, a, w, 1'b1, lat);
            checkOutput($sformatf("rand%0d/L%0d neuron", k, lanesOf(d)), int'(outNeuron[d]), val);
            checkOutput($sformatf("rand%0d/L%0d sat", k, lanesOf(d)), int'(outSat[d]), int'(sat));
            checkOutput($sformatf("rand%0d/L%0d latency", k, lanesOf(d)), lat, expLat[d]);
            @(posedge clk);
            #1;
            checkOutput($sformatf("rand%0d/L%0d xfer", k, lanesOf(d)), int'(outValid[d]), 0);
            outReady[d] = 1'b0;
        end

        $display("%0d/%0d checks passed", nPassed, nChecks);
        $finish;
    end

endmodule
